// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle word RAM responder for the load/store port
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (fault misaligned half/word accesses).
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [2:0]      lat_funct3;
  logic            lat_write;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [31:0]     shifted;
  logic            out_of_range;
  logic            misalign;
  logic            commit;
  logic            c_we;
  logic            c_err;
  logic [31:0]     c_word;
  logic [31:0]     c_rdata;

  // Decode the latched request into a commit decision, write word and response.
  always_comb begin
    idx          = lat_addr[AW+1:2];
    word         = mem[idx];
    shifted      = word >> {lat_addr[1:0], 3'b000};
    out_of_range = |lat_addr[31:AW+2];
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (lat_addr[0] && (lat_funct3 == 3'd1 || (!lat_write && lat_funct3 == 3'd5)))
             || ((lat_addr[1:0] != 2'b00) && lat_funct3 == 3'd2);
`else
    misalign = 1'b0;
`endif
    commit  = (state == ACCESS) && ((cnt == '0) || misalign);
    c_we    = 1'b0;
    c_err   = 1'b0;
    c_word  = word;
    c_rdata = 32'd0;
    if (misalign || out_of_range) begin
      c_err = 1'b1;
    end else if (lat_write) begin
      case (lat_funct3)
        3'd0: begin
          c_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
          c_we = 1'b1;
        end
        3'd1: begin
          c_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
          c_we = 1'b1;
        end
        3'd2: begin
          c_word = lat_wdata;
          c_we   = 1'b1;
        end
        default: c_err = 1'b1;
      endcase
    end else begin
      case (lat_funct3)
        3'd0, 3'd4: c_rdata = {24'd0, shifted[7:0]};
        3'd1, 3'd5: c_rdata = lat_addr[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
        3'd2:       c_rdata = word;
        default:    c_err   = 1'b1;
      endcase
    end
  end

  // FSM next-state and handshake/status outputs.
  always_comb begin
    state_next = state;
    req_ready  = ((state == IDLE) || (state == RESP)) && reset;
    accept     = req_valid && req_ready;
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (commit) state_next = RESP;
      RESP:    state_next = accept ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the accepted request and run the access latency counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_write  <= 1'b0;
    end else if (accept) begin
      cnt        <= CW'(LATENCY - 1);
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      lat_funct3 <= req_funct3;
      lat_write  <= req_write;
    end else if (state == ACCESS && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Register the response at the commit edge; it holds until the next commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= c_rdata;
      rsp_err   <= c_err;
    end
  end

  // RAM write port; contents survive reset, and a reset edge blocks the commit.
  always_ff @(posedge clk) begin
    if (reset && commit && c_we) mem[idx] <= c_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mdl [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;
  vec_t vecs [24];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int f_size(input logic w, input logic [2:0] f3);
    if (w) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Byte-addressed reference: a request touches sz bytes starting at base.
  task automatic model_op(input logic w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int cyc);
    int sz;
    int unsigned base, b, lim;
    sz  = f_size(w, f3);
    rd  = 32'd0;
    er  = 1'b0;
    cyc = LAT + 1;
    lim = 4 * DEPTH;
    if (sz == 0) begin er = 1'b1; return; end
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a % sz != 0) begin er = 1'b1; cyc = 2; return; end
    base = a;
`else
    base = a - (a % sz);
`endif
    if (a >= lim) begin er = 1'b1; return; end
    for (int i = 0; i < sz; i++) begin
      b = base + i;
      if (w) mdl[b / 4][8 * (b % 4) +: 8] = wd[8 * i +: 8];
      else   rd[8 * i +: 8] = mdl[b / 4][8 * (b % 4) +: 8];
    end
  endtask

  // Issue one request from a negedge; return at the negedge showing rsp_valid.
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int cyc);
    int t;
    req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      req_valid = 1'b0; rd = 32'hx; er = 1'bx; cyc = -1;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < LAT + 10);
    rd = rsp_rdata;
    er = rsp_err;
    if (!rsp_valid) cyc = -1;
  endtask

  task automatic run(input string nm, input logic w, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_cyc);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    issue(w, a, f3, wd, rd, er, cyc);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {31'd0, er}, {31'd0, exp_er});
    chk({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, b2b_exp [3];
    logic        er;
    int          cyc, k, pulses;
    int          acc_at [3], rsp_at [3];
    logic        acc_pending, seen;
    logic [31:0] b2b_a [3];
    logic [2:0]  b2b_f [3];
    logic        w;
    logic [31:0] a, wd;
    logic [2:0]  f3;

    vecs[0]  = '{1'b1, 32'h00, 3'd2, 32'h12345678, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h20, 3'd2, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h22, 3'd0, 32'h000000A5, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h20, 3'd2, 32'h0, 32'h00A50000, 1'b0};
    vecs[6]  = '{1'b0, 32'h22, 3'd4, 32'h0, 32'h000000A5, 1'b0};
    vecs[7]  = '{1'b0, 32'h100, 3'd2, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h100, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h00, 3'd2, 32'h0, 32'h12345678, 1'b0};
    vecs[10] = '{1'b0, 32'h13, 3'd0, 32'h0, 32'h000000DE, 1'b0};
    vecs[11] = '{1'b0, 32'h12, 3'd5, 32'h0, 32'h0000DEAD, 1'b0};
    vecs[12] = '{1'b0, 32'h10, 3'd1, 32'h0, 32'h0000BEEF, 1'b0};
    vecs[13] = '{1'b0, 32'h10, 3'd3, 32'h0, 32'h0, 1'b1};
    vecs[14] = '{1'b0, 32'h10, 3'd6, 32'h0, 32'h0, 1'b1};
    vecs[15] = '{1'b0, 32'h10, 3'd7, 32'h0, 32'h0, 1'b1};
    vecs[16] = '{1'b1, 32'h10, 3'd3, 32'h0, 32'h0, 1'b1};
    vecs[17] = '{1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[18] = '{1'b1, 32'h12, 3'd1, 32'h99991234, 32'h0, 1'b0};
    vecs[19] = '{1'b0, 32'h10, 3'd2, 32'h0, 32'h1234BEEF, 1'b0};
    vecs[20] = '{1'b0, 32'h80000010, 3'd2, 32'h0, 32'h0, 1'b1};
    vecs[21] = '{1'b1, 32'h30, 3'd2, 32'hA0A0A0A0, 32'h0, 1'b0};
    vecs[22] = '{1'b1, 32'hFC, 3'd2, 32'h5A5A0001, 32'h0, 1'b0};
    vecs[23] = '{1'b0, 32'hFE, 3'd4, 32'h0, 32'h0000005A, 1'b0};

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_funct3 = 3'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      model_op(1'b1, 32'(4 * i), 3'd2, wd, rd, er, cyc);
      run($sformatf("init%0d", i), 1'b1, 32'(4 * i), 3'd2, wd, rd, er, cyc);
    end

    for (int i = 0; i < 24; i++) begin
      model_op(vecs[i].w, vecs[i].a, vecs[i].f3, vecs[i].wd, rd, er, cyc);
      run($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].f3, vecs[i].wd,
          vecs[i].exp_rd, vecs[i].exp_er, LAT + 1);
    end

    repeat (3) @(negedge clk);
    chk("hold_rdata", rsp_rdata, 32'h0000005A);
    chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    req_write = 1'b1; req_addr = 32'h30; req_funct3 = 3'd2;
    req_wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("reset_mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("reset_mid_rdata", rsp_rdata, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("reset_mid_no_rsp", {31'd0, seen}, 32'd0);
    run("reset_mid_lw", 1'b0, 32'h30, 3'd2, 32'd0, 32'hA0A0A0A0, 1'b0, LAT + 1);

    model_op(1'b1, 32'h40, 3'd2, 32'h8765CAFE, rd, er, cyc);
    run("sw40", 1'b1, 32'h40, 3'd2, 32'h8765CAFE, 32'd0, 1'b0, LAT + 1);
`ifdef DMEM_MISALIGN_CHECK_EN
    run("lh41", 1'b0, 32'h41, 3'd1, 32'd0, 32'd0, 1'b1, 2);
`else
    run("lh41", 1'b0, 32'h41, 3'd1, 32'd0, 32'h0000CAFE, 1'b0, LAT + 1);
`endif

    b2b_a[0] = 32'h10; b2b_f[0] = 3'd2;
    b2b_a[1] = 32'h20; b2b_f[1] = 3'd2;
    b2b_a[2] = 32'h22; b2b_f[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      model_op(1'b0, b2b_a[i], b2b_f[i], 32'd0, b2b_exp[i], er, cyc);
      acc_at[i] = -1; rsp_at[i] = -1;
    end
    @(negedge clk);
    k = 0; pulses = 0; acc_pending = 1'b0;
    req_write = 1'b0; req_addr = b2b_a[0]; req_funct3 = b2b_f[0]; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (acc_pending) begin
        acc_pending = 1'b0;
        k++;
        if (k < 3) begin req_addr = b2b_a[k]; req_funct3 = b2b_f[k]; end
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (pulses < 3) begin
          chk($sformatf("b2b_rdata%0d", pulses), rsp_rdata, b2b_exp[pulses]);
          rsp_at[pulses] = c;
        end
        pulses++;
      end
      if (req_valid && req_ready && k < 3) begin acc_at[k] = c; acc_pending = 1'b1; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_accept%0d", i), 32'(acc_at[i]), 32'(i * (LAT + 1)));
      chk($sformatf("b2b_rsp%0d", i), 32'(rsp_at[i]), 32'((i + 1) * (LAT + 1)));
    end

    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4 * DEPTH + 7));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      model_op(w, a, f3, wd, rd, er, cyc);
      run($sformatf("rnd%0d", i), w, a, f3, wd, rd, er, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
